// File: rtl/fp_add_sub.sv
// Multi-cycle IEEE-754 single-precision adder (a1 + a2), round-to-nearest-even.
// Operands are captured on an accepted start. The result is produced after
// unpack, align, add, normalize and round stages. It is then held together
// with done until reset or the next accepted start.
// Denormal inputs flush to signed zero and no denormal results are produced.
module fp_add_sub (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a1,
   input  logic [31:0] a2,
   output logic [31:0] result,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      ALIGN,
      ADD,
      NORMALIZE,
      ROUND,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        op1_q, op1_d;
   logic [31:0]        op2_q, op2_d;
   logic               sign_big_q, sign_big_d;
   logic               sign_small_q, sign_small_d;
   logic [7:0]         exp_big_q, exp_big_d;
   logic [7:0]         exp_diff_q, exp_diff_d;
   logic [23:0]        mant_big_q, mant_big_d;
   logic [23:0]        mant_small_q, mant_small_d;
   logic [26:0]        small_q, small_d;
   logic [27:0]        sum_q, sum_d;
   logic [26:0]        norm_q, norm_d;
   logic signed [9:0]  exp_n_q, exp_n_d;
   logic               sign_r_q, sign_r_d;
   logic               zero_q, zero_d;
   logic [31:0]        result_q, result_d;
   logic               done_q, done_d;

   logic [7:0]         e1, e2;
   logic [23:0]        m1, m2;
   logic               nan1, nan2, inf1, inf2;
   logic               special;
   logic [31:0]        special_val;
   logic               op1_ge;
   logic [4:0]         shamt;
   logic [49:0]        shift_ext;
   logic [26:0]        big_ext;
   logic [4:0]         lz;
   logic               found;
   logic [24:0]        mant25;
   logic               round_up;
   logic signed [9:0]  exp_r;
   logic [23:0]        mant_f;

   // Classify the latched operands and pick the larger magnitude as "big"
   always_comb begin
      e1          = op1_q[30:23];
      e2          = op2_q[30:23];
      m1          = (e1 != 8'd0) ? {1'b1, op1_q[22:0]} : 24'd0;
      m2          = (e2 != 8'd0) ? {1'b1, op2_q[22:0]} : 24'd0;
      nan1        = (e1 == 8'hFF) && (op1_q[22:0] != 23'd0);
      nan2        = (e2 == 8'hFF) && (op2_q[22:0] != 23'd0);
      inf1        = (e1 == 8'hFF) && (op1_q[22:0] == 23'd0);
      inf2        = (e2 == 8'hFF) && (op2_q[22:0] == 23'd0);
      special     = nan1 || nan2 || inf1 || inf2;
      special_val = 32'h7FC00000;
      if (nan1 || nan2 || (inf1 && inf2 && (op1_q[31] != op2_q[31]))) begin
         special_val = 32'h7FC00000;
      end else if (inf1) begin
         special_val = op1_q;
      end else if (inf2) begin
         special_val = op2_q;
      end
      op1_ge = {e1, m1} >= {e2, m2};
   end

   // Right-shift the small mantissa, keeping guard/round and a sticky OR of the rest
   always_comb begin
      shamt     = (exp_diff_q > 8'd26) ? 5'd26 : exp_diff_q[4:0];
      shift_ext = {mant_small_q, 26'd0} >> shamt;
      big_ext   = {mant_big_q, 3'b000};
   end

   // Leading-zero count of the uncarried sum for single-step normalization
   always_comb begin
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && sum_q[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
         end
      end
   end

   // Round-to-nearest-even on guard/round/sticky with renormalization on overflow
   always_comb begin
      round_up = norm_q[2] && (norm_q[1] || norm_q[0] || norm_q[3]);
      mant25   = {1'b0, norm_q[26:3]} + {24'd0, round_up};
      exp_r    = exp_n_q + $signed({9'd0, mant25[24]});
      mant_f   = mant25[24] ? mant25[24:1] : mant25[23:0];
   end

   // Next-state and datapath register updates for each FSM stage
   always_comb begin
      state_d      = state_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      sign_big_d   = sign_big_q;
      sign_small_d = sign_small_q;
      exp_big_d    = exp_big_q;
      exp_diff_d   = exp_diff_q;
      mant_big_d   = mant_big_q;
      mant_small_d = mant_small_q;
      small_d      = small_q;
      sum_d        = sum_q;
      norm_d       = norm_q;
      exp_n_d      = exp_n_q;
      sign_r_d     = sign_r_q;
      zero_d       = zero_q;
      result_d     = result_q;
      done_d       = done_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op1_d   = a1;
               op2_d   = a2;
               done_d  = 1'b0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            if (special) begin
               result_d = special_val;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               if (op1_ge) begin
                  sign_big_d   = op1_q[31];
                  exp_big_d    = e1;
                  mant_big_d   = m1;
                  sign_small_d = op2_q[31];
                  mant_small_d = m2;
                  exp_diff_d   = e1 - e2;
               end else begin
                  sign_big_d   = op2_q[31];
                  exp_big_d    = e2;
                  mant_big_d   = m2;
                  sign_small_d = op1_q[31];
                  mant_small_d = m1;
                  exp_diff_d   = e2 - e1;
               end
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            small_d = {shift_ext[49:24], |shift_ext[23:0]};
            state_d = ADD;
         end
         ADD: begin
            if (sign_big_q == sign_small_q) begin
               sum_d = {1'b0, big_ext} + {1'b0, small_q};
            end else begin
               sum_d = {1'b0, big_ext} - {1'b0, small_q};
            end
            state_d = NORMALIZE;
         end
         NORMALIZE: begin
            zero_d   = 1'b0;
            sign_r_d = sign_big_q;
            if (sum_q[27]) begin
               norm_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_n_d = $signed({2'b00, exp_big_q}) + 10'sd1;
            end else if (sum_q == 28'd0) begin
               zero_d   = 1'b1;
               sign_r_d = (sign_big_q == sign_small_q) ? sign_big_q : 1'b0;
               norm_d   = 27'd0;
               exp_n_d  = 10'sd0;
            end else begin
               norm_d  = sum_q[26:0] << lz;
               exp_n_d = $signed({2'b00, exp_big_q}) - $signed({5'b00000, lz});
            end
            state_d = ROUND;
         end
         ROUND: begin
            if (zero_q) begin
               result_d = {sign_r_q, 31'd0};
            end else if (exp_r >= 10'sd255) begin
               result_d = {sign_r_q, 8'hFF, 23'd0};
            end else if (exp_r <= 10'sd0) begin
               result_d = {sign_r_q, 31'd0};
            end else begin
               result_d = {sign_r_q, exp_r[7:0], mant_f[22:0]};
            end
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         op1_q        <= 32'd0;
         op2_q        <= 32'd0;
         sign_big_q   <= 1'b0;
         sign_small_q <= 1'b0;
         exp_big_q    <= 8'd0;
         exp_diff_q   <= 8'd0;
         mant_big_q   <= 24'd0;
         mant_small_q <= 24'd0;
         small_q      <= 27'd0;
         sum_q        <= 28'd0;
         norm_q       <= 27'd0;
         exp_n_q      <= 10'sd0;
         sign_r_q     <= 1'b0;
         zero_q       <= 1'b0;
         result_q     <= 32'd0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         sign_big_q   <= sign_big_d;
         sign_small_q <= sign_small_d;
         exp_big_q    <= exp_big_d;
         exp_diff_q   <= exp_diff_d;
         mant_big_q   <= mant_big_d;
         mant_small_q <= mant_small_d;
         small_q      <= small_d;
         sum_q        <= sum_d;
         norm_q       <= norm_d;
         exp_n_q      <= exp_n_d;
         sign_r_q     <= sign_r_d;
         zero_q       <= zero_d;
         result_q     <= result_d;
         done_q       <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_fp_add_sub.sv
// Scoreboard bench for fp_add_sub: stimulus pushes expected sums, a monitor
// pops and compares on each rising edge of done. Random operands are checked
// against a reference built on double-precision arithmetic plus explicit
// round-to-nearest-even narrowing to single precision.
module tb_fp_add_sub;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a1;
   logic [31:0] a2;
   logic [31:0] result;
   logic        done;

   int          checks;
   int          failures;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        prev_done;

   fp_add_sub dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a1     (a1),
      .a2     (a2),
      .result (result),
      .done   (done)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic real to_real(input logic [31:0] x);
      logic [10:0] e11;
      if (x[30:23] == 8'd0) begin
         return $bitstoreal({x[31], 63'd0});
      end
      e11 = {3'b000, x[30:23]} + 11'd896;
      return $bitstoreal({x[31], e11, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] from_real(input real r);
      logic [63:0] b;
      logic [52:0] m;
      logic [23:0] keep;
      logic [28:0] rem;
      logic [24:0] mant;
      int          e;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) begin
         return {b[63], 31'd0};
      end
      m    = {1'b1, b[51:0]};
      keep = m[52:29];
      rem  = m[28:0];
      mant = {1'b0, keep};
      if (rem > 29'h10000000 || (rem == 29'h10000000 && keep[0])) begin
         mant = mant + 25'd1;
      end
      e = int'(b[62:52]) - 896;
      if (mant[24]) begin
         mant = mant >> 1;
         e++;
      end
      if (e >= 255) return {b[63], 8'hFF, 23'd0};
      if (e <= 0) return {b[63], 31'd0};
      return {b[63], 8'(e), mant[22:0]};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic xnan, ynan, xinf, yinf;
      xnan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      ynan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      xinf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      yinf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      if (xnan || ynan) return 32'h7FC00000;
      if (xinf && yinf) return (x[31] != y[31]) ? 32'h7FC00000 : x;
      if (xinf) return x;
      if (yinf) return y;
      return from_real(to_real(x) + to_real(y));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
      end
   endtask

   task automatic waitDone(input string name);
      int cyc;
      cyc = 0;
      while (done !== 1'b1 && cyc < 32) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s_latency: done=%b after %0d cycles, required 1 within 32", name, done, cyc);
         if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
         end
      end
   endtask

   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] expected, input string name);
      exp_q.push_back(expected);
      name_q.push_back(name);
      a1    = x;
      a2    = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(name);
   endtask

   // Monitor: every rising edge of done must match the oldest expected result
   initial begin
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_done: got result %08h with done=1, required no done", result);
            end else begin
               checkOutput(name_q.pop_front(), result, exp_q.pop_front());
            end
         end
         prev_done = done;
      end
   end

   initial begin
      logic [31:0] x, y;
      logic [7:0]  ea, eb;
      int          k;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      a1       = 32'd0;
      a2       = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_result", result, 32'h00000000);
      checkOutput("reset_done", {31'd0, done}, 32'd0);

      applyStimulus(32'h3FE00000, 32'h40500000, 32'h40A00000, "add_1p75_3p25");
      repeat (5) @(posedge clk);
      #1;
      checkOutput("done_held", {31'd0, done}, 32'd1);
      checkOutput("result_held", result, 32'h40A00000);

      applyStimulus(32'h41CA0000, 32'h40E10000, 32'h42012000, "add_25p25_7p03");
      applyStimulus(32'h40500000, 32'hBFE00000, 32'h3FC00000, "mixed_pos");
      applyStimulus(32'hC0500000, 32'h3FE00000, 32'hBFC00000, "mixed_neg");
      applyStimulus(32'h43E42666, 32'h4140F5C3, 32'h43EA2E14, "round_pos");
      applyStimulus(32'hC3E42666, 32'h4140F5C3, 32'hC3DE1EB8, "round_neg");
      applyStimulus(32'h3AA3D61A, 32'hB8CF6325, 32'h3A96DFE8, "round_small");
      applyStimulus(32'h40000000, 32'hC0000000, 32'h00000000, "cancel_zero");
      applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf");
      applyStimulus(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
      applyStimulus(32'hFF800000, 32'h3F800000, 32'hFF800000, "neg_inf_pass");
      applyStimulus(32'h7FC12345, 32'h3F800000, 32'h7FC00000, "nan_input");
      applyStimulus(32'h80000000, 32'h80000000, 32'h80000000, "negzero_sum");
      applyStimulus(32'h00400000, 32'h3F800000, 32'h3F800000, "denorm_flush");

      // A second start while busy must be ignored
      exp_q.push_back(32'h40A00000);
      name_q.push_back("busy_start_ignored");
      a1    = 32'h3FE00000;
      a2    = 32'h40500000;
      start = 1'b1;
      @(posedge clk);
      #1;
      a1 = 32'h3F800000;
      a2 = 32'h3F800000;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("busy_start_ignored");

      // Reset two cycles after start aborts the operation
      a1    = 32'h41CA0000;
      a2    = 32'h40E10000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_result", result, 32'h00000000);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("abort_done_later", {31'd0, done}, 32'd0);
      checkOutput("abort_result_later", result, 32'h00000000);

      for (int n = 0; n < 300; n++) begin
         k  = int'($urandom_range(0, 4));
         ea = 8'($urandom_range(1, 254));
         eb = ea;
         case (k)
            0: begin
               x = $urandom;
               y = $urandom;
            end
            1: begin
               x = {1'($urandom), ea, 23'($urandom)};
               y = {~x[31], ea, 23'($urandom)};
            end
            2: begin
               ea = 8'($urandom_range(3, 254));
               eb = ea - 8'($urandom_range(0, 2));
               x  = {1'($urandom), ea, 23'($urandom)};
               y  = {~x[31], eb, 23'($urandom)};
            end
            3: begin
               ea = 8'($urandom_range(40, 254));
               eb = ea - 8'($urandom_range(0, 35));
               x  = {1'($urandom), ea, 23'($urandom)};
               y  = {1'($urandom), eb, 23'($urandom)};
            end
            default: begin
               if ($urandom_range(0, 1) == 0) begin
                  ea = 8'($urandom_range(250, 254));
                  eb = 8'($urandom_range(250, 254));
               end else begin
                  ea = 8'($urandom_range(1, 4));
                  eb = 8'($urandom_range(1, 4));
               end
               x = {1'($urandom), ea, 23'($urandom)};
               y = {1'($urandom), eb, 23'($urandom)};
            end
         endcase
         if ($urandom_range(0, 1) == 0) begin
            applyStimulus(x, y, ref_add(x, y), "random");
         end else begin
            applyStimulus(y, x, ref_add(x, y), "random_swapped");
         end
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
